// File: rtl/tx_pkt.sv
`ifndef CH_IDX_W
`define CH_IDX_W 6
`endif
`ifndef NB_PKG_W
`define NB_PKG_W 8
`endif

// Byte FIFO whose read data is visible before the pop.
// Latency: a written byte is readable on the following cycle.
// Backpressure: a write while full is dropped unless a read frees the slot in the same cycle.
module tx_pkt_fifo #(
    parameter int W  = 8,
    parameter int AW = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit tells full apart from empty when the indices meet.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_dat;
    end
endmodule

// Link-layer transmitter: preamble, access address, whitened PDU and whitened CRC-24, one bit per en.
// Latency: each en cycle in a frame yields tx/tx_valid on the next cycle; first bit >= 2 cycles after start.
// Backpressure: en paces the bit stream; an empty FIFO at a byte boundary aborts the frame with underrun.
module tx_pkt #(
    parameter int          FIFO_ADDR_W = 6,
    parameter logic [23:0] CRC_INIT    = 24'h555555
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 wr_en,
    input  logic [7:0]           data_in,
    output logic                 full,
    input  logic                 start,
    input  logic [31:0]          aa,
    input  logic [`CH_IDX_W-1:0] ch_idx,
    input  logic [`NB_PKG_W-1:0] nb_pkg,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun,
    output logic                 tx,
    output logic                 tx_valid
);
    localparam logic [23:0] CRC_POLY = 24'h00065B;

    typedef enum logic [2:0] {IDLE, PRE, AA, PDU, CRC} state_t;

    state_t               state, state_n;
    logic [4:0]           bit_cnt, bit_n;
    logic [`NB_PKG_W-1:0] byte_cnt, byte_n;
    logic [31:0]          aa_r, aa_n;
    logic [7:0]           sh_r, sh_n;
    logic [23:0]          crc, crc_n;
    logic [6:0]           wh, wh_n, wh_adv;
    logic                 tx_n, tx_valid_n, done_n, underrun_n;
    logic                 fifo_pop, fifo_empty, data_bit, fb;
    logic [7:0]           fifo_dat;

    tx_pkt_fifo #(.W(8), .AW(FIFO_ADDR_W)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .push_dat (data_in),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (full),
        .empty    (fifo_empty)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            aa_r     <= '0;
            sh_r     <= '0;
            crc      <= '0;
            wh       <= '0;
            tx       <= 1'b0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_n;
            byte_cnt <= byte_n;
            aa_r     <= aa_n;
            sh_r     <= sh_n;
            crc      <= crc_n;
            wh       <= wh_n;
            tx       <= tx_n;
            tx_valid <= tx_valid_n;
            done     <= done_n;
            underrun <= underrun_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_n      = bit_cnt;
        byte_n     = byte_cnt;
        aa_n       = aa_r;
        sh_n       = sh_r;
        crc_n      = crc;
        wh_n       = wh;
        tx_n       = tx;
        tx_valid_n = 1'b0;
        done_n     = 1'b0;
        underrun_n = underrun;
        fifo_pop   = 1'b0;
        data_bit   = 1'b0;
        fb         = 1'b0;
        // Whitening step: w0<=w6, w4<=w3^w6, all other taps shift up by one.
        wh_adv     = {wh[5], wh[4], wh[3] ^ wh[6], wh[2], wh[1], wh[0], wh[6]};

        unique case (state)
            IDLE: begin
                if (start) begin
                    aa_n       = aa;
                    byte_n     = nb_pkg;
                    wh_n       = {ch_idx[0], ch_idx[1], ch_idx[2], ch_idx[3],
                                  ch_idx[4], ch_idx[5], 1'b1};
                    crc_n      = CRC_INIT;
                    bit_n      = '0;
                    underrun_n = 1'b0;
                    state_n    = PRE;
                end
            end
            PRE: begin
                if (en) begin
                    // 0xAA (aa[0]=0) or 0x55 (aa[0]=1), LSB first.
                    tx_n       = bit_cnt[0] ^ aa_r[0];
                    tx_valid_n = 1'b1;
                    if (bit_cnt == 5'd7) begin
                        bit_n   = '0;
                        state_n = AA;
                    end else begin
                        bit_n = bit_cnt + 5'd1;
                    end
                end
            end
            AA: begin
                if (en) begin
                    tx_n       = aa_r[bit_cnt];
                    tx_valid_n = 1'b1;
                    if (bit_cnt == 5'd31) begin
                        bit_n   = '0;
                        state_n = (byte_cnt != '0) ? PDU : CRC;
                    end else begin
                        bit_n = bit_cnt + 5'd1;
                    end
                end
            end
            PDU: begin
                if (en) begin
                    if (bit_cnt == 5'd0 && fifo_empty) begin
                        underrun_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        if (bit_cnt == 5'd0) begin
                            fifo_pop = 1'b1;
                            sh_n     = fifo_dat;
                            data_bit = fifo_dat[0];
                        end else begin
                            data_bit = sh_r[bit_cnt[2:0]];
                        end
                        fb         = data_bit ^ crc[23];
                        crc_n      = {crc[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h0);
                        tx_n       = data_bit ^ wh[6];
                        tx_valid_n = 1'b1;
                        wh_n       = wh_adv;
                        if (bit_cnt == 5'd7) begin
                            bit_n  = '0;
                            byte_n = byte_cnt - 1'b1;
                            if (byte_cnt == `NB_PKG_W'(1)) state_n = CRC;
                        end else begin
                            bit_n = bit_cnt + 5'd1;
                        end
                    end
                end
            end
            CRC: begin
                if (en) begin
                    tx_n       = crc[23] ^ wh[6];
                    tx_valid_n = 1'b1;
                    crc_n      = {crc[22:0], 1'b0};
                    wh_n       = wh_adv;
                    if (bit_cnt == 5'd23) begin
                        bit_n   = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        bit_n = bit_cnt + 5'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tx_pkt.sv
`ifndef CH_IDX_W
`define CH_IDX_W 6
`endif
`ifndef NB_PKG_W
`define NB_PKG_W 8
`endif

// Randomised frame bench: expected bit streams come from a byte-queue model of the FIFO
// and a bit-serial computation of preamble, address, whitening and CRC.
module tb_tx_pkt;
    logic                 clk = 1'b0;
    logic                 rst, en, wr_en, start;
    logic [7:0]           data_in;
    logic                 full;
    logic [31:0]          aa;
    logic [`CH_IDX_W-1:0] ch_idx;
    logic [`NB_PKG_W-1:0] nb_pkg;
    logic                 busy, done, underrun, tx, tx_valid;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_q[$];
    bit         exp_bits[$];
    bit         got_bits[$];

    always #5 clk = ~clk;

    tx_pkt dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .full     (full),
        .start    (start),
        .aa       (aa),
        .ch_idx   (ch_idx),
        .nb_pkg   (nb_pkg),
        .busy     (busy),
        .done     (done),
        .underrun (underrun),
        .tx       (tx),
        .tx_valid (tx_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] wstep(input logic [6:0] w);
        logic [6:0] n;
        n[0] = w[6];
        for (int i = 1; i < 7; i++) n[i] = w[i-1];
        n[4] = w[3] ^ w[6];
        return n;
    endfunction

    function automatic logic [23:0] crc_step(input logic [23:0] c, input bit d);
        logic fbit;
        fbit = d ^ c[23];
        return {c[22:0], 1'b0} ^ (fbit ? 24'h00065B : 24'h0);
    endfunction

    // Expected on-air bits; consumes PDU bytes from the FIFO model.
    task automatic build_frame(input logic [31:0] a, input logic [`CH_IDX_W-1:0] ch,
                               input int nb, output bit und);
        logic [6:0]  w;
        logic [23:0] c;
        logic [7:0]  pat, b;
        bit          d;
        exp_bits.delete();
        und = 1'b0;
        pat = a[0] ? 8'h55 : 8'hAA;
        for (int i = 0; i < 8; i++)  exp_bits.push_back(pat[i]);
        for (int i = 0; i < 32; i++) exp_bits.push_back(a[i]);
        w[0] = 1'b1;
        for (int i = 1; i < 7; i++) w[i] = ch[6-i];
        c = 24'h555555;
        for (int k = 0; k < nb; k++) begin
            if (model_q.size() == 0) begin
                und = 1'b1;
                break;
            end
            b = model_q.pop_front();
            for (int i = 0; i < 8; i++) begin
                d = b[i];
                exp_bits.push_back(d ^ w[6]);
                c = crc_step(c, d);
                w = wstep(w);
            end
        end
        if (!und) begin
            for (int i = 23; i >= 0; i--) begin
                exp_bits.push_back(c[i] ^ w[6]);
                w = wstep(w);
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        data_in = b;
        if (model_q.size() < 64) model_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // en_mode: 0 always on, 1 one cycle in three, 2 random.
    task automatic run_frame(input logic [31:0] a, input logic [`CH_IDX_W-1:0] ch, input int nb,
                             input int en_mode, input bit mid_start, input string tag);
        bit und;
        int cyc, done_cnt, stray;
        build_frame(a, ch, nb, und);
        got_bits.delete();
        @(negedge clk);
        aa     = a;
        ch_idx = ch;
        nb_pkg = `NB_PKG_W'(nb);
        start  = 1'b1;
        en     = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        cyc      = 0;
        done_cnt = 0;
        while (busy && cyc < 4000) begin
            case (en_mode)
                0:       en = 1'b1;
                1:       en = (cyc % 3 == 0);
                default: en = 1'($urandom_range(0, 1));
            endcase
            start = mid_start && (cyc == 30);
            @(negedge clk);
            cyc++;
            if (tx_valid) got_bits.push_back(tx);
            if (done) begin
                done_cnt++;
                chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            end
        end
        start = 1'b0;
        chk({tag, "_no_timeout"}, 32'(cyc < 4000), 32'd1);
        chk({tag, "_len"}, 32'(got_bits.size()), 32'(exp_bits.size()));
        for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
            chk($sformatf("%s_bit%0d", tag, i), 32'(got_bits[i]), 32'(exp_bits[i]));
        chk({tag, "_done_cnt"}, 32'(done_cnt), und ? 32'd0 : 32'd1);
        chk({tag, "_underrun"}, 32'(underrun), 32'(und));
        en    = 1'b1;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (tx_valid || done || busy) stray++;
        end
        chk({tag, "_quiet_after"}, 32'(stray), 32'd0);
        chk({tag, "_underrun_sticky"}, 32'(underrun), 32'(und));
    endtask

    initial begin
        logic [7:0]  v8;
        logic [31:0] v32;
        int          nv, nb, extra;

        rst = 1'b1; en = 1'b0; wr_en = 1'b0; start = 1'b0;
        data_in = '0; aa = '0; ch_idx = '0; nb_pkg = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        nv  = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_valid) nv++;
        end
        chk("idle_tx_valid_cnt", 32'(nv), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_full", 32'(full), 32'd0);
        chk("idle_underrun", 32'(underrun), 32'd0);
        chk("idle_tx", 32'(tx), 32'd0);

        // Empty PDU: 64 bits, preamble 0xAA, address as given.
        run_frame(32'h8E89BED6, `CH_IDX_W'(37), 0, 0, 1'b0, "nopdu");
        if (got_bits.size() >= 40) begin
            for (int i = 0; i < 8; i++)  v8[i]  = got_bits[i];
            for (int i = 0; i < 32; i++) v32[i] = got_bits[8+i];
            chk("nopdu_preamble", 32'(v8), 32'h000000AA);
            chk("nopdu_aa", v32, 32'h8E89BED6);
        end

        push_byte(8'h02); push_byte(8'h01); push_byte(8'hA5); push_byte(8'h3C);
        run_frame(32'h8E89BED6, `CH_IDX_W'(37), 4, 1, 1'b0, "loop4");

        for (int i = 0; i < 64; i++) push_byte(8'($urandom));
        chk("fill64_full", 32'(full), 32'd1);
        push_byte(8'hEE);
        chk("fill65_full", 32'(full), 32'd1);
        run_frame($urandom, `CH_IDX_W'($urandom), 64, 2, 1'b0, "full64");
        chk("full64_drained", 32'(full), 32'd0);

        push_byte(8'h5A); push_byte(8'hC3);
        run_frame(32'h12345679, `CH_IDX_W'(9), 3, 0, 1'b0, "underrun");

        for (int f = 0; f < 6; f++) begin
            nb    = $urandom_range(1, 12);
            extra = $urandom_range(0, 3);
            for (int i = 0; i < nb + extra; i++) push_byte(8'($urandom));
            run_frame($urandom, `CH_IDX_W'($urandom), nb, f % 3, (f == 1),
                      $sformatf("rand%0d", f));
        end

        // Reset in the middle of the access address.
        model_q.delete();
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        @(negedge clk);
        aa = 32'hCAFEF00D; ch_idx = `CH_IDX_W'(5); nb_pkg = `NB_PKG_W'(2);
        start = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        model_q.delete();
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid_full", 32'(full), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        rst = 1'b0;
        run_frame(32'h0F0F0F0F, `CH_IDX_W'(21), 1, 0, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
